zx_contention_sched: RTL and testbench
======================================

// Module: zx_contention_sched
// PURPOSE
//  Schedules shared video-RAM access between the screen fetcher and the Z80.
//  Tracks T-state/line position in the frame and, for CPU memory or ULA-port
//  accesses that hit contended memory during active display, requests CPU
//  clock stall cycles using the 6,5,4,3,2,1,0,0 pattern.
//  Sits beside the ULA screen controller. The stall output gates the Z80 clock
//  downstream. clkcpu here is the free-running, ungated T-state clock.
// PARAMETERS
//  T_LINE    224  T-states per scan line (tc wraps at T_LINE-1)
//  LINES     320  lines per frame (lc wraps at LINES-1)
//  ACT_LINES 192  contended lines, lc 0..ACT_LINES-1
//  ACT_T     128  contended T-states per line, tc 0..ACT_T-1
// PORTS
//  clkcpu      in   1  T-state clock, free-running
//  rst_n       in   1  async reset, active-low
//  en          in   1  1 = contention enabled; 0 = never stall
//  frame_sync  in   1  1-cycle pulse: frame origin (tc=0, lc=0 next cycle)
//  n_mreq      in   1  Z80 memory request, active-low
//  n_iorq      in   1  Z80 I/O request, active-low
//  n_rfsh      in   1  Z80 refresh, active-low; refresh cycles never contend
//  a15,a14     in   1  CPU address bits 15:14
//  a0          in   1  CPU address bit 0 (ULA port when 0)
//  rambank     in   3  current #7FFD RAM bank at C000-FFFF
//  stall       out  1  1 = hold CPU clock this cycle
//  contended   out  1  1 = current access classified as contended (debug)
//  tc          out  8  T-state within line
//  lc          out  9  line within frame
// BEHAVIOUR
//  - Async reset: tc=0, lc=0, FSM=IDLE, stall=0, contended=0, edge regs=1.
//    Reset mid-stall drops stall immediately.
//  - Counters: tc increments each clkcpu. At T_LINE-1, tc->0 and lc increments.
//    At lc=LINES-1 and tc=T_LINE-1, lc->0.
//    frame_sync forces tc=0, lc=0 on the next edge, overriding the increment.
//    Counters run during stall.
//  - Access start: falling edge of n_mreq (registered prev=1, now=0) with
//    n_rfsh=1, OR falling edge of n_iorq with a0=0.
//  - Contended address: {a15,a14}=01, or {a15,a14}=11 with rambank[0]=1
//    (banks 1,3,5,7). ULA port (a0=0) is always contended.
//  - Window: lc<ACT_LINES and tc<ACT_T.
//    delay = {6,5,4,3,2,1,0,0}[tc[2:0]], else 0.
//    Delay is computed from the tc/lc values in the start cycle, before any
//    frame_sync applied in that same cycle.
//  - FSM:
//    IDLE -> STALL when start, contended address, en=1, window open, and
//      delay>0. Load cnt=delay. contended=1.
//    IDLE -> DONE when start occurs but no stall is needed. contended is
//      set to the address classification.
//    STALL: stall=1 and cnt decrements each cycle. At cnt=1, go to DONE.
//      stall is registered: high from the cycle after start for exactly
//      delay cycles.
//    DONE: stall=0. Return to IDLE when n_mreq=1 and n_iorq=1. This
//      prevents re-triggering within one access. contended clears on
//      return to IDLE.
//  - en falling during STALL: finish the current count; no new stalls start.
//  - Simultaneous n_mreq and n_iorq start is illegal on Z80. n_iorq
//    takes priority.
//  - Last window T-state (tc=ACT_T-1, delay=0) and tc=ACT_T: no stall.
//    Line 191 contends; line 192 does not.
// TESTING
//  1. Reset, frame_sync, access at lc=0, tc=0 to bank 5 (a15:14=01)
//     -> stall high for 6 cycles starting 1 cycle after the n_mreq fall.
//  2. Same access at tc=5 / tc=6 -> 1 stall cycle / 0 stall cycles.
//     At tc=6, contended=1.
//  3. rambank=2, a15:14=11 at tc=0 -> no stall, contended=0.
//     rambank=7 -> 6 stall cycles.
//  4. IN from port FE (a0=0) at lc=191, tc=8 -> 6 stalls.
//     Same at lc=192 -> 0 stalls.
//  5. Refresh cycle (n_rfsh=0) to bank 5 at tc=0 -> no stall.
//     With en=0 -> no stall anywhere.
//  6. Assert rst_n=0 on stall cycle 3 -> stall=0 immediately; tc=lc=0.
//     tc wrap: 223->0 with lc+1; lc 319->0.

Source files
------------

// File: rtl/zx_contention_sched.sv
// Frame position tracker and CPU contention scheduler for shared video RAM.
// Requests Z80 clock stalls (6,5,4,3,2,1,0,0 pattern) for contended accesses in the display window.
module zx_contention_sched #(
    parameter int T_LINE    = 224,
    parameter int LINES     = 320,
    parameter int ACT_LINES = 192,
    parameter int ACT_T     = 128
) (
    input  logic       clkcpu,
    input  logic       rst_n,
    input  logic       en,
    input  logic       frame_sync,
    input  logic       n_mreq,
    input  logic       n_iorq,
    input  logic       n_rfsh,
    input  logic       a15,
    input  logic       a14,
    input  logic       a0,
    input  logic [2:0] rambank,
    output logic       stall,
    output logic       contended,
    output logic [7:0] tc,
    output logic [8:0] lc
);

    typedef enum logic [1:0] {IDLE, STALL, DONE} state_t;

    state_t     state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic       contended_nxt;
    logic       prev_mreq, prev_iorq;
    logic       start_mem, start_io, start;
    logic       addr_cont, window;
    logic [2:0] delay;
    logic       unused_bank;

    assign unused_bank = ^rambank[2:1];

    // Frame position counters keep running while the CPU is stalled.
    always_ff @(posedge clkcpu or negedge rst_n) begin
        if (!rst_n) begin
            tc <= 8'd0;
            lc <= 9'd0;
        end else if (frame_sync) begin
            tc <= 8'd0;
            lc <= 9'd0;
        end else if (tc == 8'(T_LINE - 1)) begin
            tc <= 8'd0;
            lc <= (lc == 9'(LINES - 1)) ? 9'd0 : lc + 9'd1;
        end else begin
            tc <= tc + 8'd1;
        end
    end

    always_ff @(posedge clkcpu or negedge rst_n) begin
        if (!rst_n) begin
            prev_mreq <= 1'b1;
            prev_iorq <= 1'b1;
        end else begin
            prev_mreq <= n_mreq;
            prev_iorq <= n_iorq;
        end
    end

    // An I/O start wins over a simultaneous memory start and always hits the ULA port.
    assign start_io  = prev_iorq && !n_iorq && !a0;
    assign start_mem = prev_mreq && !n_mreq && n_rfsh;
    assign start     = start_io || start_mem;
    assign addr_cont = start_io ? 1'b1
                     : ((!a15 && a14) || (a15 && a14 && rambank[0]));
    assign window    = (lc < 9'(ACT_LINES)) && (tc < 8'(ACT_T));

    always_comb begin
        delay = 3'd0;
        if (window) begin
            case (tc[2:0])
                3'd0:    delay = 3'd6;
                3'd1:    delay = 3'd5;
                3'd2:    delay = 3'd4;
                3'd3:    delay = 3'd3;
                3'd4:    delay = 3'd2;
                3'd5:    delay = 3'd1;
                default: delay = 3'd0;
            endcase
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        contended_nxt = contended;
        case (state)
            IDLE: begin
                contended_nxt = 1'b0;
                if (start) begin
                    contended_nxt = addr_cont;
                    if (addr_cont && en && (delay != 3'd0)) begin
                        state_nxt = STALL;
                        cnt_nxt   = delay;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            STALL: begin
                cnt_nxt = cnt - 3'd1;
                if (cnt == 3'd1) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // Wait for the access to end so one access cannot trigger twice.
                if (n_mreq && n_iorq) begin
                    state_nxt     = IDLE;
                    contended_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt     = IDLE;
                contended_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clkcpu or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            contended <= 1'b0;
            stall     <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            contended <= contended_nxt;
            stall     <= (state_nxt == STALL);
        end
    end

endmodule

// File: tb/tb_zx_contention_sched.sv
// Scoreboard bench for zx_contention_sched: randomized Z80 accesses against a frame-position reference model.
module tb_zx_contention_sched;

    localparam int TL    = 224;
    localparam int NL    = 320;
    localparam int FRAME = TL * NL;

    logic       clkcpu = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic       frame_sync = 1'b0;
    logic       n_mreq = 1'b1;
    logic       n_iorq = 1'b1;
    logic       n_rfsh = 1'b1;
    logic       a15 = 1'b0;
    logic       a14 = 1'b0;
    logic       a0 = 1'b1;
    logic [2:0] rambank = 3'd0;
    logic       stall;
    logic       contended;
    logic [7:0] tc;
    logic [8:0] lc;

    typedef struct {
        int tc;
        int lc;
        int len;
        int cont;
    } exp_t;

    exp_t sb[$];
    event issued;
    int   checks = 0;
    int   errors = 0;
    int   pos = 0;

    zx_contention_sched dut (
        .clkcpu     (clkcpu),
        .rst_n      (rst_n),
        .en         (en),
        .frame_sync (frame_sync),
        .n_mreq     (n_mreq),
        .n_iorq     (n_iorq),
        .n_rfsh     (n_rfsh),
        .a15        (a15),
        .a14        (a14),
        .a0         (a0),
        .rambank    (rambank),
        .stall      (stall),
        .contended  (contended),
        .tc         (tc),
        .lc         (lc)
    );

    always #5 clkcpu = ~clkcpu;

    task automatic checkOutput(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d (model lc=%0d tc=%0d)",
                     name, act, expv, pos / TL, pos % TL);
        end
    endtask

    // Advance one clock; the model position follows the frame rules directly.
    task automatic tick();
        @(posedge clkcpu);
        if (!rst_n || frame_sync) pos = 0;
        else pos = (pos + 1) % FRAME;
        #1;
    endtask

    task automatic syncFrame();
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
    endtask

    task automatic waitPos(input int wl, input int wt);
        int n = 0;
        while (pos != wl * TL + wt && n < FRAME + 1000) begin
            tick();
            n++;
        end
        if (pos != wl * TL + wt) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_pos actual=%0d expected=%0d", pos, wl * TL + wt);
        end
    endtask

    // kind: 0 = memory, 1 = I/O, 2 = both requests falling together.
    task automatic applyStimulus(input int kind, input logic ia15, input logic ia14,
                                 input logic ia0, input logic [2:0] bank,
                                 input logic rfsh, input logic ien, input logic ifs);
        exp_t e;
        int   ptc, plc, d;
        bit   io_start, mem_start, cls;
        a15 = ia15; a14 = ia14; a0 = ia0; rambank = bank;
        n_rfsh = rfsh; en = ien; frame_sync = ifs;
        n_mreq = (kind != 1) ? 1'b0 : 1'b1;
        n_iorq = (kind != 0) ? 1'b0 : 1'b1;
        ptc = pos % TL;
        plc = pos / TL;
        io_start  = (kind != 0) && !ia0;
        mem_start = (kind != 1) && rfsh;
        if (io_start) cls = 1'b1;
        else if (mem_start) cls = ({ia15, ia14} == 2'b01) || ({ia15, ia14} == 2'b11 && bank[0]);
        else cls = 1'b0;
        d = 0;
        if (plc < 192 && ptc < 128 && (ptc % 8) < 7) d = 6 - (ptc % 8);
        e.tc   = ptc;
        e.lc   = plc;
        e.cont = (io_start || mem_start) ? int'(cls) : 0;
        e.len  = ((io_start || mem_start) && cls && ien) ? d : 0;
        sb.push_back(e);
        -> issued;
        tick();
        frame_sync = 1'b0;
        n_rfsh = 1'b1;
        repeat (7) begin
            if ($urandom_range(0, 3) == 0) en = 1'($urandom_range(0, 1));
            tick();
        end
        n_mreq = 1'b1;
        n_iorq = 1'b1;
        repeat ($urandom_range(1, 4)) tick();
    endtask

    task automatic randomAccess(input bit allow_fs);
        int k;
        k = $urandom_range(0, 9);
        applyStimulus((k < 6) ? 0 : ((k < 9) ? 1 : 2),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 7) != 0),
                      allow_fs && ($urandom_range(0, 9) == 0));
    endtask

    // Monitor: pops the expected response for each access and measures the DUT.
    initial begin
        exp_t e;
        int   run, total;
        bit   broken;
        forever begin
            @(issued);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL sb_underflow actual=0 expected=1");
            end else begin
                e = sb.pop_front();
                @(negedge clkcpu);
                checkOutput("tc_at_start", tc, e.tc);
                checkOutput("lc_at_start", lc, e.lc);
                checkOutput("stall_at_start", stall, 0);
                run = 0; total = 0; broken = 0;
                for (int k = 1; k <= 7; k++) begin
                    @(negedge clkcpu);
                    if (k == 1) checkOutput("contended", contended, e.cont);
                    if (stall) begin
                        total++;
                        if (!broken) run++;
                    end else begin
                        broken = 1;
                    end
                end
                checkOutput("stall_len", run, e.len);
                checkOutput("stall_total", total, e.len);
            end
        end
    end

    initial begin
        #20;
        checkOutput("rst_tc", tc, 0);
        checkOutput("rst_lc", lc, 0);
        checkOutput("rst_stall", stall, 0);
        checkOutput("rst_contended", contended, 0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // Reset asserted on the third stall cycle drops stall at once.
        syncFrame();
        a15 = 1'b0; a14 = 1'b1; en = 1'b1; n_mreq = 1'b0;
        repeat (3) tick();
        checkOutput("stall_cycle3", stall, 1);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_stall", stall, 0);
        checkOutput("midrst_tc", tc, 0);
        checkOutput("midrst_lc", lc, 0);
        checkOutput("midrst_contended", contended, 0);
        n_mreq = 1'b1;
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        syncFrame(); applyStimulus(0, 1'b0, 1'b1, 1'b1, 3'd5, 1'b1, 1'b1, 1'b0);
        syncFrame(); waitPos(0, 5); applyStimulus(0, 1'b0, 1'b1, 1'b1, 3'd5, 1'b1, 1'b1, 1'b0);
        syncFrame(); waitPos(0, 6); applyStimulus(0, 1'b0, 1'b1, 1'b1, 3'd5, 1'b1, 1'b1, 1'b0);
        syncFrame(); applyStimulus(0, 1'b1, 1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0);
        syncFrame(); applyStimulus(0, 1'b1, 1'b1, 1'b1, 3'd7, 1'b1, 1'b1, 1'b0);
        syncFrame(); applyStimulus(0, 1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 1'b1, 1'b0);
        syncFrame(); applyStimulus(0, 1'b0, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0);
        syncFrame(); applyStimulus(1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        syncFrame(); waitPos(0, 127); applyStimulus(0, 1'b0, 1'b1, 1'b1, 3'd5, 1'b1, 1'b1, 1'b0);
        syncFrame(); waitPos(0, 128); applyStimulus(0, 1'b0, 1'b1, 1'b1, 3'd5, 1'b1, 1'b1, 1'b0);
        syncFrame(); applyStimulus(0, 1'b0, 1'b1, 1'b1, 3'd5, 1'b1, 1'b1, 1'b1);

        for (int i = 0; i < 150; i++) randomAccess(1'b1);

        syncFrame();
        waitPos(5, 223);
        checkOutput("wrap_tc_pre", tc, 223);
        checkOutput("wrap_lc_pre", lc, 5);
        tick();
        checkOutput("wrap_tc_post", tc, 0);
        checkOutput("wrap_lc_post", lc, 6);

        while (pos < 191 * TL - 20) randomAccess(1'b0);
        waitPos(191, 8); applyStimulus(1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
        waitPos(192, 8); applyStimulus(1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);

        waitPos(319, 223);
        checkOutput("fwrap_tc_pre", tc, 223);
        checkOutput("fwrap_lc_pre", lc, 319);
        tick();
        checkOutput("fwrap_tc_post", tc, 0);
        checkOutput("fwrap_lc_post", lc, 0);

        repeat (12) tick();
        checkOutput("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
